clause_sr_sched: RTL and testbench

- Scheduler for one clause-storage shift register (N-bit, shifts right when its shift-enable is high, sin enters at the MSB, sout = q[0]).
- Shares that register between two requesters:
  - the clause loader, which serially writes a new clause word;
  - the clause evaluator, which reads the word serially without destroying it, by rotating it.
- Sits between the solver's load/eval control and a single clause register.
- Owns the register's shift-enable and sin.

---
 rtl/clause_sr_sched.sv | 83 ++++++++
 tb/tb_clause_sr_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clause_sr_sched.sv
// Arbitrates one clause shift register between a serial loader (write) and a
// non-destructive serial evaluator (read by rotation); owns shift-enable and sin.
`timescale 1ns/1ps
module clause_sr_sched #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wr_req,
  input  logic wr_valid,
  input  logic wr_bit,
  output logic wr_ready,
  output logic wr_gnt,
  input  logic rd_req,
  output logic rd_gnt,
  output logic rd_valid,
  output logic rd_bit,
  output logic busy,
  output logic done,
  output logic sr_load,
  output logic sr_sin,
  input  logic sr_sout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_rd;  // 1: read was served last, so write wins a tie
  logic          cur_rd;   // op currently being served is a read
  logic          in_wr, in_rd, step;

  assign in_wr = (state == S_WRITE);
  assign in_rd = (state == S_READ);
  assign step  = (in_wr && wr_valid) || in_rd;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_req && (!rd_req || last_rd)) state_nxt = S_WRITE;
        else if (rd_req)                    state_nxt = S_READ;
      end
      S_WRITE: if (wr_valid && cnt == LAST) state_nxt = S_DONE;
      S_READ:  if (cnt == LAST)             state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last_rd <= 1'b1;
      cur_rd  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_DONE) cnt <= '0;
      else if (step)           cnt <= cnt + CW'(1);
      if (state == S_IDLE)     cur_rd  <= (state_nxt == S_READ);
      if (state == S_DONE)     last_rd <= cur_rd;
    end
  end

  // Grants and busy decode straight from the state register, so they rise on
  // the edge that leaves IDLE and fall on the edge that enters DONE.
  assign wr_gnt   = in_wr;
  assign rd_gnt   = in_rd;
  assign busy     = in_wr | in_rd;
  assign done     = (state == S_DONE);
  assign wr_ready = in_wr;
  assign sr_load  = step;
  assign sr_sin   = in_wr ? wr_bit : (in_rd ? sr_sout : 1'b0);
  assign rd_valid = in_rd;
  assign rd_bit   = in_rd & sr_sout;

endmodule

// File: tb/tb_clause_sr_sched.sv
// Directed bench for clause_sr_sched driving a behavioural 8-bit shift register.
`timescale 1ns/1ps
module tb_clause_sr_sched;
  localparam int N = 8;

  logic clk = 0, reset_n = 0;
  logic wr_req = 0, wr_valid = 0, wr_bit = 0, rd_req = 0;
  logic wr_ready, wr_gnt, rd_gnt, rd_valid, rd_bit, busy, done, sr_load, sr_sin, sr_sout;
  logic [N-1:0] q;
  int errors = 0, checks = 0, cyc = 0;

  clause_sr_sched #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_valid(wr_valid), .wr_bit(wr_bit), .wr_ready(wr_ready), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_bit(rd_bit),
    .busy(busy), .done(done), .sr_load(sr_load), .sr_sin(sr_sin), .sr_sout(sr_sout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Clause register: shifts right, sin at MSB, never reset.
  always @(posedge clk) if (sr_load) q <= {sr_sin, q[N-1:1]};
  assign sr_sout = q[0];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [8:0] all_outs();
    return {wr_gnt, rd_gnt, busy, done, wr_ready, rd_valid, rd_bit, sr_load, sr_sin};
  endfunction

  task automatic do_reset;
    reset_n = 0; #3;
    chk("rst_outs", all_outs(), 9'd0);
    @(negedge clk); reset_n = 1;
    tick;
  endtask

  task automatic do_write(input logic [N-1:0] w, input bit stall);
    int acc = 0, t0;
    wr_req = 1;
    @(negedge clk); chk("wr_idle_gnt", wr_gnt, 0);
    tick; t0 = cyc;
    for (int i = 0; i < 40 && acc < N; i++) begin
      wr_valid = stall ? i[0] : 1'b1;
      wr_bit   = w[acc];
      @(negedge clk);
      if (i == 0) chk("wr_gnt", {wr_gnt, busy, wr_ready, rd_gnt}, 4'b1110);
      chk("wr_load", sr_load, wr_valid);
      if (wr_valid) begin
        chk("wr_sin", sr_sin, wr_bit);
        acc++;
      end
      tick;
    end
    wr_valid = 0; wr_req = 0; wr_bit = 0;
    chk("wr_accepted", acc, N);
    @(negedge clk);
    chk("wr_done", {done, wr_gnt, busy, sr_load}, 4'b1000);
    chk("wr_done_cyc", cyc - t0, stall ? 16 : 8);
    chk("wr_q", q, w);
    tick;
    @(negedge clk); chk("wr_idle", {done, busy, sr_load}, 3'b000);
    tick;
  endtask

  task automatic read_body(input logic [N-1:0] exp);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("rd_bit", {rd_gnt, busy, rd_valid, sr_load, sr_sin, rd_bit}, {4'b1111, exp[i], exp[i]});
      tick;
    end
    @(negedge clk);
    chk("rd_done", {done, rd_gnt, rd_valid, busy}, 4'b1000);
    chk("rd_q", q, exp);
    tick;
  endtask

  task automatic do_read(input logic [N-1:0] exp);
    rd_req = 1;
    @(negedge clk); chk("rd_idle_gnt", rd_gnt, 0);
    tick; rd_req = 0;
    read_body(exp);
  endtask

  initial begin
    int nd, ng, gcyc[4], dcyc[4];
    logic [3:0] ops;
    logic prev_w, prev_r, overlap;
    logic [N-1:0] w;

    // Reset state, and wr_valid in IDLE must not shift.
    #2;
    do_reset;
    wr_valid = 1; wr_bit = 1;
    @(negedge clk); chk("idle_wrvalid", {sr_load, wr_ready, busy}, 3'b000);
    tick; wr_valid = 0; wr_bit = 0;

    do_write(8'hA5, 0);
    do_read(8'hA5);
    do_write(8'h3C, 1);

    // Both requesters held: round-robin from write priority after reset.
    do_reset;
    wr_req = 1; rd_req = 1; wr_valid = 1; wr_bit = 1;
    nd = 0; ng = 0; ops = 0; prev_w = 0; prev_r = 0; overlap = 0;
    for (int k = 0; k < 4; k++) begin gcyc[k] = 0; dcyc[k] = 0; end
    for (int i = 0; i < 100 && nd < 4; i++) begin
      @(negedge clk);
      if (wr_gnt && rd_gnt) overlap = 1;
      if ((wr_gnt && !prev_w) || (rd_gnt && !prev_r)) begin
        if (ng < 4) begin ops[ng] = rd_gnt; gcyc[ng] = cyc; end
        ng++;
      end
      if (done) begin
        if (nd < 4) dcyc[nd] = cyc;
        nd++;
      end
      prev_w = wr_gnt; prev_r = rd_gnt;
      tick;
    end
    wr_req = 0; rd_req = 0; wr_valid = 0; wr_bit = 0;
    chk("both_dones", nd, 4);
    chk("both_order", ops, 4'b1010);
    chk("both_overlap", overlap, 0);
    for (int k = 0; k < 3; k++) chk("both_gap", gcyc[k+1] - dcyc[k], 2);
    @(negedge clk); chk("both_q", q, 8'hFF);
    tick;

    // rd_req arrives mid-write, wr_req drops at bit 3: write still completes.
    w = 8'h5A;
    wr_req = 1;
    tick;
    for (int i = 0; i < N; i++) begin
      wr_valid = 1; wr_bit = w[i];
      if (i == 1) rd_req = 1;
      if (i == 3) wr_req = 0;
      @(negedge clk); chk("mid_wr", {wr_gnt, rd_gnt, sr_load}, 3'b101);
      tick;
    end
    wr_valid = 0; wr_bit = 0;
    @(negedge clk); chk("mid_done", {done, rd_gnt}, 2'b10); chk("mid_q", q, w);
    tick;
    @(negedge clk); chk("mid_idle", {rd_gnt, busy, done}, 3'b000);
    tick; rd_req = 0;
    read_body(w);

    // Reset during read cycle 4: three rotations already happened.
    rd_req = 1;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tick;
    end
    reset_n = 0; #1;
    chk("rst_mid_outs", all_outs(), 9'd0);
    @(negedge clk);
    chk("rst_mid_hold", all_outs(), 9'd0);
    reset_n = 1;
    tick; rd_req = 0;
    read_body({w[2:0], w[N-1:3]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
